// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: one DIGIT-bit slice of a WIDTH-bit add per cycle, with
// valid/ready handshakes on both sides and optional signed saturation.
module digit_serial_adder #(
    parameter int WIDTH    = 16,
    parameter int DIGIT    = 4,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST  = KW'(N - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d;

    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   dsum;
    logic             accept, msb_cin;

    assign a_sl = a_q[int'(k_q)*DIGIT +: DIGIT];
    assign b_sl = b_q[int'(k_q)*DIGIT +: DIGIT];
    assign dsum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from its sum bit.
    assign msb_cin = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ dsum[DIGIT-1];

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                res_d[int'(k_q)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
                carry_d = dsum[DIGIT];
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    c_out_d = dsum[DIGIT];
                    ovf_d   = dsum[DIGIT] ^ msb_cin;
                    sum_d   = res_d;
                    if ((SATURATE != 0) && ovf_d)
                        sum_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready && !in_valid)
                    state_d = IDLE;
            end
            default: ;
        endcase

        // Acceptance from IDLE, or from DONE in the same cycle the result leaves.
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = c_in;
            k_d     = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
